// File: rtl/rob_retire_buf.sv
// rob_retire_buf: in-order retire buffer with out-of-order writeback.
// Entries are allocated in program order and retired up to RETIRE_W per cycle.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   alloc_valid/ready/tag      in-order allocation, tag = tail slot
//   wb_valid/tag/data          writeback marks a busy entry done
//   flush                      drops every entry, pointers to zero
//   ret_valid/tag/data/ready   contiguous retire lanes from head
//   count                      occupied entries
//   retired_cnt                retire statistics
// Optional: define ROB_RETIRE_STATS_EN to enable the retired_cnt counter;
// otherwise retired_cnt is tied to zero.
module rob_retire_buf #(
    parameter int  DEPTH    = 16,
    parameter int  DATA_W   = 32,
    parameter int  RETIRE_W = 2,
    localparam int TAG_W    = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    output logic [TAG_W-1:0]           alloc_tag,
    input  logic                       wb_valid,
    input  logic [TAG_W-1:0]           wb_tag,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       flush,
    output logic [RETIRE_W-1:0]        ret_valid,
    output logic [RETIRE_W*TAG_W-1:0]  ret_tag,
    output logic [RETIRE_W*DATA_W-1:0] ret_data,
    input  logic                       ret_ready,
    output logic [TAG_W:0]             count,
    output logic [31:0]                retired_cnt
);

    // Pointers carry a wrap bit so full and empty are distinguishable.
    logic [TAG_W:0]      head_q;
    logic [TAG_W:0]      tail_q;
    logic [DEPTH-1:0]    busy_q;
    logic [DEPTH-1:0]    done_q;
    logic [DEPTH-1:0]    busy_d;
    logic [DEPTH-1:0]    done_d;
    logic [DATA_W-1:0]   data_q [DEPTH];
    logic [TAG_W-1:0]    lane_idx [RETIRE_W];
    logic [TAG_W:0]      n_ret;
    logic                do_alloc;
    logic                do_wb;
    logic                do_ret;

    assign count       = tail_q - head_q;
    assign alloc_ready = (count != (TAG_W+1)'(DEPTH));
    assign alloc_tag   = tail_q[TAG_W-1:0];

    // Flush wins over every other operation in the same cycle. The busy
    // check uses registered state, so a same-cycle allocation is not yet
    // a legal writeback target.
    assign do_alloc = alloc_valid && alloc_ready && !flush;
    assign do_wb    = wb_valid && busy_q[wb_tag] && !flush;
    assign do_ret   = ret_ready && ret_valid[0] && !flush;

    // Lanes stay contiguous: the first not-ready entry stops the scan.
    always_comb begin
        logic run;
        run       = 1'b1;
        ret_valid = '0;
        ret_tag   = '0;
        ret_data  = '0;
        n_ret     = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            lane_idx[i] = head_q[TAG_W-1:0] + TAG_W'(i);
            if (run && busy_q[lane_idx[i]] && done_q[lane_idx[i]]) begin
                ret_valid[i]                 = 1'b1;
                ret_tag[i*TAG_W +: TAG_W]    = lane_idx[i];
                ret_data[i*DATA_W +: DATA_W] = data_q[lane_idx[i]];
                n_ret                        = n_ret + (TAG_W+1)'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    // Writeback, allocation and retire touch disjoint slots: writeback
    // needs a busy slot, allocation takes a free one, and a retiring slot
    // is cleared last.
    always_comb begin
        busy_d = busy_q;
        done_d = done_q;
        if (do_wb) begin
            done_d[wb_tag] = 1'b1;
        end
        if (do_alloc) begin
            busy_d[alloc_tag] = 1'b1;
            done_d[alloc_tag] = 1'b0;
        end
        if (do_ret) begin
            for (int i = 0; i < RETIRE_W; i++) begin
                if (ret_valid[i]) begin
                    busy_d[lane_idx[i]] = 1'b0;
                    done_d[lane_idx[i]] = 1'b0;
                end
            end
        end
        if (flush) begin
            busy_d = '0;
            done_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            busy_q <= '0;
            done_q <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            if (flush) begin
                head_q <= '0;
                tail_q <= '0;
            end else begin
                if (do_ret) begin
                    head_q <= head_q + n_ret;
                end
                if (do_alloc) begin
                    tail_q <= tail_q + (TAG_W+1)'(1);
                end
            end
        end
    end

    // Payload needs no reset: it is only visible behind busy && done.
    always_ff @(posedge clk) begin
        if (do_wb) begin
            data_q[wb_tag] <= wb_data;
        end
    end

`ifdef ROB_RETIRE_STATS_EN
    logic [31:0] retired_q;

    // Counts lanes actually retired; flush suppresses retire, so it
    // never adds here, but it does not clear the counter either.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (do_ret) begin
            retired_q <= retired_q + 32'(n_ret);
        end
    end

    assign retired_cnt = retired_q;
`else
    assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_rob_retire_buf.sv
// tb_rob_retire_buf: directed stimulus with a retire scoreboard.
// Stimulus queues expected (tag, data) per allocation; a monitor pops on retire.
module tb_rob_retire_buf;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 32;
    localparam int RW     = 2;
    localparam int TW     = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 alloc_valid = 1'b0;
    logic                 alloc_ready;
    logic [TW-1:0]        alloc_tag;
    logic                 wb_valid = 1'b0;
    logic [TW-1:0]        wb_tag = '0;
    logic [DATA_W-1:0]    wb_data = '0;
    logic                 flush = 1'b0;
    logic [RW-1:0]        ret_valid;
    logic [RW*TW-1:0]     ret_tag;
    logic [RW*DATA_W-1:0] ret_data;
    logic                 ret_ready = 1'b0;
    logic [TW:0]          count;
    logic [31:0]          retired_cnt;

    rob_retire_buf #(
        .DEPTH(DEPTH),
        .DATA_W(DATA_W),
        .RETIRE_W(RW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .alloc_valid(alloc_valid),
        .alloc_ready(alloc_ready),
        .alloc_tag(alloc_tag),
        .wb_valid(wb_valid),
        .wb_tag(wb_tag),
        .wb_data(wb_data),
        .flush(flush),
        .ret_valid(ret_valid),
        .ret_tag(ret_tag),
        .ret_data(ret_data),
        .ret_ready(ret_ready),
        .count(count),
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0]     tag;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              sbq[$];
    exp_t              mon_e;
    int                n_chk = 0;
    int                n_fail = 0;
    logic [TW-1:0]     exp_tag = '0;
    logic [DATA_W-1:0] tag_data [DEPTH];
    logic [31:0]       want_rc;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        alloc_valid = 1'b0;
        wb_valid    = 1'b0;
        flush       = 1'b0;
        ret_ready   = 1'b0;
        sbq.delete();
        exp_tag = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic alloc(input logic [DATA_W-1:0] d);
        chk("alloc_ready", alloc_ready, 1);
        chk("alloc_tag", alloc_tag, exp_tag);
        tag_data[exp_tag] = d;
        sbq.push_back('{exp_tag, d});
        alloc_valid = 1'b1;
        cyc();
        alloc_valid = 1'b0;
        exp_tag = exp_tag + 1'b1;
    endtask

    task automatic wb(input logic [TW-1:0] t);
        wb_valid = 1'b1;
        wb_tag   = t;
        wb_data  = tag_data[t];
        cyc();
        wb_valid = 1'b0;
    endtask

    // Scoreboard monitor: every lane that retires must match program order.
    always @(negedge clk) begin
        if (rst_n && !flush && ret_ready && ret_valid[0]) begin
            for (int i = 0; i < RW; i++) begin
                if (ret_valid[i]) begin
                    if (sbq.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL sb_underflow: lane %0d tag %0d, none expected",
                                 i, ret_tag[i*TW +: TW]);
                    end else begin
                        mon_e = sbq.pop_front();
                        chk("sb_tag", ret_tag[i*TW +: TW], mon_e.tag);
                        chk("sb_data", ret_data[i*DATA_W +: DATA_W], mon_e.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TW-1:0] t;
        logic [TW-1:0] prev_tag;
        logic          wrapped;

`ifdef ROB_RETIRE_STATS_EN
        want_rc = 32'd5;
`else
        want_rc = 32'd0;
`endif

        // Reset state, sampled while reset is held
        #2;
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_alloc_tag", alloc_tag, 0);
        chk("rst_ret_valid", ret_valid, 0);
        chk("rst_ret_tag", ret_tag, 0);
        chk("rst_ret_data", ret_data, 0);
        chk("rst_count", count, 0);
        chk("rst_retired_cnt", retired_cnt, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Scenario 1: out-of-order writeback, in-order retire
        alloc(32'hA000_0000);
        alloc(32'hA000_0001);
        alloc(32'hA000_0002);
        chk("s1_count", count, 3);
        wb(2);
        chk("s1_rv_none", ret_valid, 2'b00);
        wb(0);
        chk("s1_rv_lane0", ret_valid, 2'b01);
        chk("s1_data0", ret_data, 64'h0000_0000_A000_0000);
        chk("s1_tag0", ret_tag, 6'o00);
        cyc();
        cyc();
        chk("s1_rv_hold", ret_valid, 2'b01);
        wb(1);
        chk("s1_rv_both", ret_valid, 2'b11);
        chk("s1_tag01", ret_tag, 6'o10);
        ret_ready = 1'b1;
        cyc();
        chk("s1_rv_tag2", ret_valid, 2'b01);
        chk("s1_tag2", ret_tag, 6'o02);
        cyc();
        ret_ready = 1'b0;
        chk("s1_count_end", count, 0);
        chk("s1_rv_end", ret_valid, 2'b00);

        // Scenario 2: full buffer, retire does not free same-cycle slot
        do_reset();
        for (int i = 0; i < 8; i++) alloc(32'hB000_0000 + 32'(i));
        chk("s2_count_full", count, 8);
        chk("s2_not_ready", alloc_ready, 0);
        wb(0);
        wb(1);
        chk("s2_rv", ret_valid, 2'b11);
        alloc_valid = 1'b1;
        ret_ready   = 1'b1;
        cyc();
        alloc_valid = 1'b0;
        ret_ready   = 1'b0;
        chk("s2_count_after", count, 6);
        chk("s2_ready_again", alloc_ready, 1);
        alloc(32'hB100_0000);
        chk("s2_count_7", count, 7);

        // Scenario 3: hold under backpressure, then dual retire
        do_reset();
        alloc(32'hC000_0000);
        alloc(32'hC000_0001);
        wb(0);
        wb(1);
        for (int k = 0; k < 5; k++) begin
            chk("s3_rv_stable", ret_valid, 2'b11);
            chk("s3_tag_stable", ret_tag, 6'o10);
            chk("s3_data_stable", ret_data, 64'hC000_0001_C000_0000);
            cyc();
        end
        ret_ready = 1'b1;
        cyc();
        ret_ready = 1'b0;
        chk("s3_count", count, 0);
        chk("s3_rv_empty", ret_valid, 2'b00);
        alloc(32'hC000_0002);
        wb(2);
        chk("s3_head2_tag", ret_tag, 6'o02);
        chk("s3_head2_rv", ret_valid, 2'b01);
        ret_ready = 1'b1;
        cyc();
        ret_ready = 1'b0;

        // Scenario 4: 20 allocate/retire pairs, tags wrap 7 -> 0
        wrapped  = 1'b0;
        prev_tag = alloc_tag;
        for (int k = 0; k < 20; k++) begin
            t = exp_tag;
            if (prev_tag == 3'd7 && alloc_tag == 3'd0) wrapped = 1'b1;
            prev_tag = alloc_tag;
            alloc(32'hD000_0000 + 32'(k));
            chk("s4_count_max", count <= 4'd8, 1);
            chk("s4_count1", count, 1);
            wb(t);
            chk("s4_rv", ret_valid, 2'b01);
            ret_ready = 1'b1;
            cyc();
            ret_ready = 1'b0;
            chk("s4_count0", count, 0);
        end
        chk("s4_wrapped", wrapped, 1);

        // Scenario 5: flush beats alloc, writeback and retire
        do_reset();
        alloc(32'hE000_0000);
        alloc(32'hE000_0001);
        wb(0);
        wb(1);
        flush       = 1'b1;
        alloc_valid = 1'b1;
        wb_valid    = 1'b1;
        wb_tag      = 3'd1;
        wb_data     = 32'hDEAD_BEEF;
        ret_ready   = 1'b1;
        sbq.delete();
        cyc();
        flush       = 1'b0;
        alloc_valid = 1'b0;
        wb_valid    = 1'b0;
        ret_ready   = 1'b0;
        exp_tag     = '0;
        chk("s5_count", count, 0);
        chk("s5_rv", ret_valid, 2'b00);
        chk("s5_tag", alloc_tag, 0);
        chk("s5_data", ret_data, 0);
        alloc(32'hE000_0005);
        wb(0);
        chk("s5_rv_new", ret_valid, 2'b01);
        chk("s5_data_new", ret_data, 64'h0000_0000_E000_0005);
        ret_ready = 1'b1;
        cyc();
        ret_ready = 1'b0;

        // Scenario 6: statistics and reset mid-retire
        do_reset();
        for (int i = 0; i < 5; i++) alloc(32'hF000_0000 + 32'(i));
        for (int i = 0; i < 5; i++) wb(3'(i));
        chk("s6_rv", ret_valid, 2'b11);
        ret_ready = 1'b1;
        cyc();
        cyc();
        chk("s6_rv_last", ret_valid, 2'b01);
        cyc();
        ret_ready = 1'b0;
        chk("s6_count", count, 0);
        chk("s6_retired", retired_cnt, want_rc);
        alloc(32'hF000_0005);
        alloc(32'hF000_0006);
        wb(5);
        wb(6);
        ret_ready = 1'b1;
        #1;
        rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("s6_rst_retired", retired_cnt, 0);
        chk("s6_rst_count", count, 0);
        chk("s6_rst_rv", ret_valid, 0);
        chk("s6_rst_ready", alloc_ready, 1);
        chk("s6_rst_tag", alloc_tag, 0);
        chk("s6_rst_rtag", ret_tag, 0);
        chk("s6_rst_rdata", ret_data, 0);
        ret_ready = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        exp_tag = '0;
        cyc();
        chk("s6_post_count", count, 0);
        chk("s6_post_retired", retired_cnt, 0);

        chk("sb_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rob_retire_buf.md
ROB_RETIRE_BUF -- requirements
Module: rob_retire_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the entry count; power of 2, range 4..64.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the writeback payload width.
REQ-003 SHALL have parameter RETIRE_W, default 2, meaning the maximum entries retired per cycle; range 1..4.
REQ-004 SHALL define TAG_W = log2(DEPTH), derived.
REQ-005 clk  input  1  the single clock; all state SHALL be on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 alloc_valid  input  1  request to allocate one entry in program order.
REQ-008 alloc_ready  output  1  an entry is free.
REQ-009 alloc_tag  output  TAG_W  tag granted when alloc_valid && alloc_ready.
REQ-010 wb_valid  input  1  writeback strobe.
REQ-011 wb_tag  input  TAG_W  writeback target entry.
REQ-012 wb_data  input  DATA_W  writeback payload.
REQ-013 flush  input  1  discard all entries.
REQ-014 ret_valid  output  RETIRE_W  per-lane retire valid.
REQ-015 ret_tag  output  RETIRE_W*TAG_W  per-lane tag; lane i is at bits [i*TAG_W +: TAG_W].
REQ-016 ret_data  output  RETIRE_W*DATA_W  per-lane payload.
REQ-017 ret_ready  input  1  consumer accepts all valid lanes.
REQ-018 count  output  TAG_W+1  occupied entries.
REQ-019 retired_cnt  output  32  retire statistics (see Configuration).

Function
REQ-020 Storage SHALL be a circular buffer with head/tail pointers of TAG_W+1 bits, using the wrap bit to distinguish full from empty; each entry holds busy, done and data.
REQ-021 alloc_ready SHALL equal (count != DEPTH), computed from registered state only; a retire in the same cycle SHALL NOT free a slot for that cycle's allocation.
REQ-022 On allocation: alloc_tag = tail[TAG_W-1:0]; the entry is set busy=1, done=0; tail increments, wrapping modulo 2*DEPTH.
REQ-023 A writeback to a busy entry SHALL set done=1 and store data; a writeback to a non-busy entry, including one allocated in the same cycle, SHALL be ignored.
REQ-024 ret_valid[i] SHALL be 1 iff entries head..head+i are all busy && done; lanes are contiguous from lane 0, so no gaps are permitted.
REQ-025 Latency: a writeback in cycle N SHALL be visible on ret_valid in cycle N+1; outputs are driven from registered state only.
REQ-026 When ret_ready && ret_valid[0], all valid lanes retire: those entries are cleared and head advances by the popcount of ret_valid, wrapping around.
REQ-027 When ret_ready=0, ret_valid/ret_tag/ret_data of valid lanes SHALL remain stable; more lanes may become valid.
REQ-028 Invalid lanes SHALL drive ret_tag=0 and ret_data=0.
REQ-029 count SHALL become count + alloc - retired on the next edge.
REQ-030 flush SHALL have priority over alloc, writeback and retire in the same cycle; the next cycle SHALL give head=tail=0, all busy/done=0 and count=0.

Reset
REQ-031 rst_n low SHALL immediately force head=tail=0, all busy/done=0 and retired_cnt=0.
REQ-032 Under reset, outputs SHALL be alloc_ready=1, alloc_tag=0, ret_valid=0, ret_tag=0, ret_data=0 and count=0.
REQ-033 Reset asserted mid-retire or mid-allocation SHALL abort the operation with no partial update.

Configuration
REQ-034 With ROB_RETIRE_STATS_EN defined, retired_cnt SHALL add the number of lanes retired each cycle; it wraps at 2^32 and is unaffected by flush.
REQ-035 Without ROB_RETIRE_STATS_EN, retired_cnt SHALL be tied to 0 and no counter logic SHALL be present.

Verification (DEPTH=8, RETIRE_W=2, DATA_W=32)
REQ-036 Scenario 1: allocate 3 entries, writeback tag2 then tag0; expect ret_valid=2'b01 with data of tag0, and tag2 held until tag1 is written.
REQ-037 Scenario 2: allocate 8 entries; expect alloc_ready=0 and count=8; retire 2 with an alloc in the same cycle; expect the alloc refused, then alloc_tag=0 granted next cycle.
REQ-038 Scenario 3: tags 0 and 1 done with ret_ready=0 for 5 cycles; expect ret_valid=2'b11 stable; on ret_ready=1, both retire and head advances by 2.
REQ-039 Scenario 4: run 20 allocate/retire pairs; expect tags to wrap 7->0 with count never exceeding 8.
REQ-040 Scenario 5: flush concurrently with alloc, wb and ret_ready; expect count=0, ret_valid=0 and alloc_tag=0 the next cycle.
REQ-041 Scenario 6: with ROB_RETIRE_STATS_EN, retire 5 entries then assert rst_n=0 mid-stream; expect retired_cnt=5, then 0 immediately on reset.
